// File: rtl/denise_colortable_writer.sv
// Write-side front end for the Denise AGA colour table: decodes BPLCON3 and
// COLOR00-31 writes, merges low-nibble writes with a high-nibble shadow RAM,
// and queues 24-bit colour words for issue in granted write slots.
module denise_colortable_writer #(
  parameter int unsigned DEPTH = 4,
  parameter bit          AGA   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] data_in,
  input  logic        reg_we,
  input  logic        ct_slot,
  output logic        ct_wren,
  output logic [7:0]  ct_wraddress,
  output logic [31:0] ct_data,
  output logic [3:0]  ct_byteena,
  output logic        ct_overflow
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned SH_W    = 12;
  localparam logic [7:0]  BPLCON3 = 8'h83;

  // Register decode
  logic             is_bplcon3;
  logic             is_color;
  logic [2:0]       bank;
  logic             loct;
  logic [IDX_W-1:0] idx;

  assign is_bplcon3 = reg_we && (reg_addr == BPLCON3);
  assign is_color   = reg_we && (reg_addr[7:5] == 3'b110);
  assign idx        = {bank, reg_addr[4:0]};

  // data_in[12] carries nothing this block consumes
  logic unused_bits;
  assign unused_bits = data_in[12];

  // BANK/LOCT tracking; ECS mode pins both to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank <= 3'd0;
      loct <= 1'b0;
    end else if (is_bplcon3) begin
      bank <= AGA ? data_in[15:13] : 3'd0;
      loct <= AGA ? data_in[9] : 1'b0;
    end
  end

  // High-nibble shadow RAM: synchronous read-before-write, never cleared
  logic [SH_W-1:0] shadow [2**IDX_W];
  logic [SH_W-1:0] sh_q;

  always_ff @(posedge clk) begin
    if (is_color) begin
      sh_q <= shadow[idx];
      if (!loct) shadow[idx] <= data_in[SH_W-1:0];
    end
  end

  // Stage 1: captured colour write awaiting word assembly
  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic [12:0]      s1_data;
  logic             s1_loct;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_data  <= '0;
      s1_loct  <= 1'b0;
    end else begin
      s1_valid <= is_color;
      if (is_color) begin
        s1_idx  <= idx;
        s1_data <= {data_in[15], data_in[11:0]};
        s1_loct <= loct;
      end
    end
  end

  // Colour word assembly: low writes borrow the high nibbles from the shadow
  logic [RGB_W-1:0] ent_rgb;
  logic             ent_t;
  logic [3:0]       ent_be;

  always_comb begin
    ent_rgb = {s1_data[11:8], s1_data[11:8], s1_data[7:4], s1_data[7:4],
               s1_data[3:0], s1_data[3:0]};
    ent_t   = s1_data[12];
    ent_be  = 4'b1111;
    if (s1_loct) begin
      ent_rgb = {sh_q[11:8], s1_data[11:8], sh_q[7:4], s1_data[7:4],
                 sh_q[3:0], s1_data[3:0]};
      ent_t   = 1'b0;
      ent_be  = 4'b0111;
    end
  end

  // Write queue (first-word-fall-through)
  logic [IDX_W-1:0] q_addr [DEPTH];
  logic [RGB_W-1:0] q_rgb  [DEPTH];
  logic             q_t    [DEPTH];
  logic [3:0]       q_be   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic [IDX_W-1:0] last_addr;
  logic [RGB_W:0]   last_tc;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign ct_wren = ct_slot && !empty;
  assign push_ok = s1_valid && (!full || ct_wren);

  // Queue storage, written only when a push is accepted
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_addr[wr_ptr] <= s1_idx;
      q_rgb[wr_ptr]  <= ent_rgb;
      q_t[wr_ptr]    <= ent_t;
      q_be[wr_ptr]   <= ent_be;
    end
  end

  // Queue pointers, occupancy, sticky overflow and last-issued hold values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ct_overflow <= 1'b0;
      last_addr   <= '0;
      last_tc     <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (ct_wren) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        last_addr <= q_addr[rd_ptr];
        last_tc   <= {q_t[rd_ptr], q_rgb[rd_ptr]};
      end
      if (push_ok && !ct_wren)      count <= count + CNT_W'(1);
      else if (!push_ok && ct_wren) count <= count - CNT_W'(1);
      if (s1_valid && !push_ok) ct_overflow <= 1'b1;
    end
  end

  // Head entry drives the port; address/data hold the last issue when empty
  always_comb begin
    ct_wraddress = last_addr;
    ct_data      = {7'd0, last_tc};
    ct_byteena   = 4'b0000;
    if (!empty) begin
      ct_wraddress = q_addr[rd_ptr];
      ct_data      = {7'd0, q_t[rd_ptr], q_rgb[rd_ptr]};
      ct_byteena   = q_be[rd_ptr];
    end
  end

endmodule
